// File: rtl/tictactoe_game_ctrl_if.sv
// Move handshake bundle between a player front-end and the game controller.
//  move_valid/move_cell/move_player : request from the player side
//  move_ready                       : controller can take a move this cycle
//  move_ack/move_err                : 1-cycle result pulses
//  move_err_code                    : reason of the last rejection (held)
interface tictactoe_game_ctrl_if;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] move_cell;
    logic       move_player;
    logic       move_ack;
    logic       move_err;
    logic [1:0] move_err_code;

    modport master (
        output move_valid, move_cell, move_player,
        input  move_ready, move_ack, move_err, move_err_code
    );

    modport slave (
        input  move_valid, move_cell, move_player,
        output move_ready, move_ack, move_err, move_err_code
    );
endinterface

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game controller: takes moves over a valid/ready handshake, enforces
// turn order and cell legality, keeps the X/O boards and declares win/draw/forfeit.
//  clk, rst       : clock, synchronous active-high reset
//  start          : begin a new game (any state, wins over a same-cycle move)
//  mv             : move handshake (slave side)
//  x_board/o_board: occupied cells, bit i = cell row*3+col
//  turn           : player expected next (0=X, 1=O)
//  game_over, win_x, win_o, draw, timeout : game result flags
module tictactoe_game_ctrl #(
    parameter bit          FIRST_PLAYER = 1'b0,
    parameter int unsigned MOVE_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    tictactoe_game_ctrl_if.slave        mv,
    output logic [8:0]                  x_board,
    output logic [8:0]                  o_board,
    output logic                        turn,
    output logic                        game_over,
    output logic                        win_x,
    output logic                        win_o,
    output logic                        draw,
    output logic                        timeout
);

    localparam int unsigned TW = (MOVE_TIMEOUT == 0) ? 1 : $clog2(MOVE_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(MOVE_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_MOVE, EVAL, DONE} state_t;

    state_t        state_q, state_d;
    logic [8:0]    x_q, x_d, o_q, o_d;
    logic          turn_q, turn_d, wx_q, wx_d, wo_q, wo_d;
    logic          draw_q, draw_d, to_q, to_d;
    logic          ack_q, ack_d, err_q, err_d, ready_q, ready_d, over_q, over_d;
    logic [1:0]    code_q, code_d;
    logic [TW-1:0] timer_q, timer_d;

    logic       hs, cell_bad, wrong_pl, occupied, legal, expire, line_hit, full;
    logic [8:0] cell_mask;

    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Move legality; cells 9..15 shift out of the mask, so they never look occupied
    assign cell_mask = 9'd1 << mv.move_cell;
    assign cell_bad  = mv.move_cell > 4'd8;
    assign wrong_pl  = mv.move_player != turn_q;
    assign occupied  = |((x_q | o_q) & cell_mask);
    assign hs        = (state_q == WAIT_MOVE) && mv.move_valid && !start;
    assign legal     = hs && !cell_bad && !wrong_pl && !occupied;
    // An accepted move in the expiry cycle beats the forfeit
    assign expire    = (MOVE_TIMEOUT != 0) && (state_q == WAIT_MOVE) && !start &&
                       !legal && (timer_q == T_LAST);
    // Only the player who just moved can have completed a line
    assign line_hit  = has_line(turn_q ? o_q : x_q);
    assign full      = &(x_q | o_q);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            o_q     <= '0;
            turn_q  <= FIRST_PLAYER;
            wx_q    <= 1'b0;
            wo_q    <= 1'b0;
            draw_q  <= 1'b0;
            to_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            over_q  <= 1'b0;
            code_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            o_q     <= o_d;
            turn_q  <= turn_d;
            wx_q    <= wx_d;
            wo_q    <= wo_d;
            draw_q  <= draw_d;
            to_q    <= to_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            over_q  <= over_d;
            code_q  <= code_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = WAIT_MOVE;
        end else begin
            case (state_q)
                WAIT_MOVE: begin
                    if (legal)       state_d = EVAL;
                    else if (expire) state_d = DONE;
                end
                EVAL:    state_d = (line_hit || full) ? DONE : WAIT_MOVE;
                default: state_d = state_q;
            endcase
        end
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        x_d     = x_q;
        o_d     = o_q;
        turn_d  = turn_q;
        wx_d    = wx_q;
        wo_d    = wo_q;
        draw_d  = draw_q;
        to_d    = to_q;
        code_d  = code_q;
        timer_d = timer_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        ready_d = (state_d == WAIT_MOVE);
        over_d  = (state_d == DONE);
        if (start) begin
            x_d     = '0;
            o_d     = '0;
            wx_d    = 1'b0;
            wo_d    = 1'b0;
            draw_d  = 1'b0;
            to_d    = 1'b0;
            code_d  = '0;
            turn_d  = FIRST_PLAYER;
            timer_d = '0;
        end else begin
            case (state_q)
                WAIT_MOVE: begin
                    if (hs && !legal) begin
                        err_d  = 1'b1;
                        code_d = cell_bad ? 2'b01 : (wrong_pl ? 2'b10 : 2'b11);
                    end
                    if (legal) begin
                        ack_d = 1'b1;
                        if (turn_q) o_d = o_q | cell_mask;
                        else        x_d = x_q | cell_mask;
                    end else if (expire) begin
                        to_d = 1'b1;
                        if (turn_q) wx_d = 1'b1;
                        else        wo_d = 1'b1;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                EVAL: begin
                    if (line_hit) begin
                        if (turn_q) wo_d = 1'b1;
                        else        wx_d = 1'b1;
                    end else if (full) begin
                        draw_d = 1'b1;
                    end else begin
                        turn_d  = ~turn_q;
                        timer_d = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mv.move_ready    = ready_q;
    assign mv.move_ack      = ack_q;
    assign mv.move_err      = err_q;
    assign mv.move_err_code = code_q;
    assign x_board          = x_q;
    assign o_board          = o_q;
    assign turn             = turn_q;
    assign game_over        = over_q;
    assign win_x            = wx_q;
    assign win_o            = wo_q;
    assign draw             = draw_q;
    assign timeout          = to_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Scoreboard bench for tictactoe_game_ctrl: stimulus queues expected move
// responses and status snapshots; a monitor on the falling edge compares them.
module tb_tictactoe_game_ctrl;
    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [8:0] x_board, o_board;
    logic       turn, game_over, win_x, win_o, draw, timeout;

    tictactoe_game_ctrl_if mif();

    tictactoe_game_ctrl #(.FIRST_PLAYER(1'b0), .MOVE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mv(mif),
        .x_board(x_board), .o_board(o_board), .turn(turn), .game_over(game_over),
        .win_x(win_x), .win_o(win_o), .draw(draw), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [1:0] code;
        logic [8:0] x;
        logic [8:0] o;
    } mv_exp_t;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] o;
        logic       tu, ov, wx, wo, dr, to, rdy;
        logic [1:0] code;
    } st_exp_t;

    mv_exp_t mq[$];
    st_exp_t sq[$];
    string   sname[$];
    int      checks = 0;
    int      failures = 0;
    bit      end_req = 1'b0;
    bit      mon_done = 1'b0;

    // Monitor: compares every DUT response and every requested snapshot
    initial begin
        mv_exp_t e, a;
        st_exp_t s, sa;
        string   nm;
        forever begin
            @(negedge clk);
            if (mif.move_ack || mif.move_err) begin
                checks++;
                if (mif.move_ack && mif.move_err) begin
                    failures++;
                    $display("FAIL ack_err_both: ack=%b err=%b, required only one", mif.move_ack, mif.move_err);
                end else if (mq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp: ack=%b err=%b, required no response", mif.move_ack, mif.move_err);
                end else begin
                    e = mq.pop_front();
                    a.err  = mif.move_err;
                    a.code = e.err ? mif.move_err_code : e.code;
                    a.x    = x_board;
                    a.o    = o_board;
                    if (a !== e) begin
                        failures++;
                        $display("FAIL move_resp: got err=%b code=%b x=%h o=%h, required err=%b code=%b x=%h o=%h",
                                 a.err, a.code, a.x, a.o, e.err, e.code, e.x, e.o);
                    end
                end
            end
            if (sq.size() != 0) begin
                s  = sq.pop_front();
                nm = sname.pop_front();
                sa = {x_board, o_board, turn, game_over, win_x, win_o, draw, timeout,
                      mif.move_ready, mif.move_err_code};
                checks++;
                if (sa !== s) begin
                    failures++;
                    $display("FAIL %s: got x=%h o=%h turn=%b over=%b wx=%b wo=%b draw=%b to=%b rdy=%b code=%b, required x=%h o=%h turn=%b over=%b wx=%b wo=%b draw=%b to=%b rdy=%b code=%b",
                             nm, sa.x, sa.o, sa.tu, sa.ov, sa.wx, sa.wo, sa.dr, sa.to, sa.rdy, sa.code,
                             s.x, s.o, s.tu, s.ov, s.wx, s.wo, s.dr, s.to, s.rdy, s.code);
                end
            end
            if (end_req && !mon_done) begin
                checks++;
                if (mq.size() != 0 || sq.size() != 0) begin
                    failures++;
                    $display("FAIL leftover: got %0d moves %0d snapshots pending, required 0", mq.size(), sq.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap(input string nm, input logic [8:0] x, input logic [8:0] o,
                        input logic tu, input logic ov, input logic wx, input logic wo,
                        input logic dr, input logic to, input logic rdy, input logic [1:0] code);
        st_exp_t s;
        s = {x, o, tu, ov, wx, wo, dr, to, rdy, code};
        sq.push_back(s);
        sname.push_back(nm);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_move(input logic [3:0] c, input logic p, input logic e,
                           input logic [1:0] code, input logic [8:0] x, input logic [8:0] o);
        int n;
        mv_exp_t m;
        m = {e, code, x, o};
        mq.push_back(m);
        mif.move_valid  = 1'b1;
        mif.move_cell   = c;
        mif.move_player = p;
        n = 0;
        while (!mif.move_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!mif.move_ready) begin
            $display("FAIL ready_wait: got move_ready=0 after %0d cycles, required 1", n);
            $fatal(1);
        end
        tick(1);
        mif.move_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        mif.move_valid = 1'b0;
        mif.move_cell = 4'd0;
        mif.move_player = 1'b0;
        tick(3);
        snap("reset", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        rst = 1'b0;
        tick(1);

        // X wins on the top row
        do_start();
        snap("t1_start", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 1, 2'b00);
        do_move(4'd0, 1'b0, 1'b0, 2'b00, 9'h001, 9'h000);
        do_move(4'd3, 1'b1, 1'b0, 2'b00, 9'h001, 9'h008);
        do_move(4'd1, 1'b0, 1'b0, 2'b00, 9'h003, 9'h008);
        do_move(4'd4, 1'b1, 1'b0, 2'b00, 9'h003, 9'h018);
        do_move(4'd2, 1'b0, 1'b0, 2'b00, 9'h007, 9'h018);
        tick(1);
        snap("t1_win_x", 9'h007, 9'h018, 0, 1, 1, 0, 0, 0, 0, 2'b00);

        // Occupied cell rejected, turn stays with O
        do_start();
        do_move(4'd4, 1'b0, 1'b0, 2'b00, 9'h010, 9'h000);
        do_move(4'd4, 1'b1, 1'b1, 2'b11, 9'h010, 9'h000);
        snap("t2_occupied", 9'h010, 9'h000, 1, 0, 0, 0, 0, 0, 1, 2'b11);

        // Wrong player, then bad cell; start clears the held code
        do_start();
        snap("t3_start", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 1, 2'b00);
        do_move(4'd0, 1'b1, 1'b1, 2'b10, 9'h000, 9'h000);
        do_move(4'd9, 1'b0, 1'b1, 2'b01, 9'h000, 9'h000);
        snap("t3_errs", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 1, 2'b01);

        // Full board, no winner
        do_start();
        do_move(4'd0, 1'b0, 1'b0, 2'b00, 9'h001, 9'h000);
        do_move(4'd1, 1'b1, 1'b0, 2'b00, 9'h001, 9'h002);
        do_move(4'd2, 1'b0, 1'b0, 2'b00, 9'h005, 9'h002);
        do_move(4'd4, 1'b1, 1'b0, 2'b00, 9'h005, 9'h012);
        do_move(4'd3, 1'b0, 1'b0, 2'b00, 9'h00D, 9'h012);
        do_move(4'd5, 1'b1, 1'b0, 2'b00, 9'h00D, 9'h032);
        do_move(4'd7, 1'b0, 1'b0, 2'b00, 9'h08D, 9'h032);
        do_move(4'd6, 1'b1, 1'b0, 2'b00, 9'h08D, 9'h072);
        do_move(4'd8, 1'b0, 1'b0, 2'b00, 9'h18D, 9'h072);
        tick(1);
        snap("t4_draw", 9'h18D, 9'h072, 0, 1, 0, 0, 1, 0, 0, 2'b00);

        // Forfeit after 8 idle cycles
        do_start();
        tick(7);
        snap("t5_pre_expiry", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 1, 2'b00);
        tick(1);
        snap("t5_timeout", 9'h000, 9'h000, 0, 1, 0, 1, 0, 1, 0, 2'b00);

        // Move accepted in the expiry cycle beats the forfeit
        do_start();
        tick(7);
        do_move(4'd0, 1'b0, 1'b0, 2'b00, 9'h001, 9'h000);
        tick(1);
        snap("t5_late_move", 9'h001, 9'h000, 1, 0, 0, 0, 0, 0, 1, 2'b00);

        // start wins over a same-cycle move: no response expected
        start = 1'b1;
        mif.move_valid = 1'b1;
        mif.move_cell = 4'd2;
        mif.move_player = 1'b1;
        tick(1);
        start = 1'b0;
        mif.move_valid = 1'b0;
        snap("t6_restart", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 1, 2'b00);

        // rst mid-game beats start
        do_move(4'd0, 1'b0, 1'b0, 2'b00, 9'h001, 9'h000);
        rst = 1'b1;
        start = 1'b1;
        tick(1);
        snap("t6_rst", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        rst = 1'b0;
        start = 1'b0;
        tick(10);
        snap("t6_idle_hold", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick(1);

        end_req = 1'b1;
        n = 0;
        while (!mon_done && n < 10) begin
            tick(1);
            n++;
        end
        if (!mon_done) begin
            $display("FAIL monitor_end: got no monitor completion, required completion");
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
